// File: rtl/memgame_timer_pkg.sv
// Shared types and defaults for the round countdown timer.
package memgame_timer_pkg;

  localparam int unsigned DEFAULT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    DONE
  } timer_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the incoming tick stream by TicksPerUnit and emits one unit_step per full count.
module tick_prescaler #(
  parameter int unsigned TicksPerUnit = 1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  input  logic tick_i,
  input  logic clr_i,
  output logic unit_step_o
);

  localparam int unsigned CntW = (TicksPerUnit > 1) ? $clog2(TicksPerUnit) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(TicksPerUnit - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            count;

  assign count       = en_i & tick_i;
  // With a single tick per unit the counter stays at 0 and every counted tick is a step.
  assign unit_step_o = count & (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (count) begin
      cnt_d = (cnt_q == LastCnt) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/round_timer.sv
// Round countdown timer: loads a unit count on start and counts down on prescaled ticks.
// Optional near-expiry warning output is built when ROUND_TIMER_WARN_EN is defined.
module round_timer
  import memgame_timer_pkg::*;
#(
  parameter int unsigned W              = DEFAULT_W,
  parameter int unsigned TICKS_PER_UNIT = 1,
  parameter int unsigned WARN_THRESH    = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         start,
  input  logic [W-1:0] load_val,
  input  logic         pause,
  input  logic         clear,
  output logic [W-1:0] remaining,
  output logic         running,
  output logic         expired,
  output logic         done,
  output logic         warn
);

  timer_state_t state_q, state_d;
  logic [W-1:0] remaining_q, remaining_d;
  logic         running_q, running_d;
  logic         expired_q, expired_d;
  logic         done_q, done_d;
  logic         unit_step;
  logic         presc_en;
  logic         presc_clr;

  // Ticks only count in RUN with no higher-priority control active on the same edge.
  assign presc_en  = (state_q == RUN) & ~pause & ~clear & ~start;
  assign presc_clr = clear | start;

  tick_prescaler #(
    .TicksPerUnit(TICKS_PER_UNIT)
  ) u_tick_prescaler (
    .clk_i      (clk),
    .reset_i    (reset),
    .en_i       (presc_en),
    .tick_i     (tick),
    .clr_i      (presc_clr),
    .unit_step_o(unit_step)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    expired_d   = 1'b0;
    if (clear) begin
      state_d     = IDLE;
      remaining_d = '0;
    end else if (start) begin
      remaining_d = load_val;
      if (load_val == '0) begin
        state_d   = DONE;
        expired_d = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else begin
      unique case (state_q)
        RUN: begin
          if (pause) begin
            state_d = PAUSED;
          end else if (unit_step) begin
            remaining_d = remaining_q - 1'b1;
            if (remaining_q == W'(1)) begin
              state_d   = DONE;
              expired_d = 1'b1;
            end
          end
        end
        PAUSED: begin
          if (!pause) begin
            state_d = RUN;
          end
        end
        default: ;
      endcase
    end
    running_d = (state_d == RUN) || (state_d == PAUSED);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      running_q   <= 1'b0;
      expired_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      running_q   <= running_d;
      expired_q   <= expired_d;
      done_q      <= done_d;
    end
  end

  assign remaining = remaining_q;
  assign running   = running_q;
  assign expired   = expired_q;
  assign done      = done_q;

`ifdef ROUND_TIMER_WARN_EN
  logic warn_q, warn_d;

  always_comb begin
    warn_d = running_d && (remaining_d != '0) && (remaining_d <= W'(WARN_THRESH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      warn_q <= 1'b0;
    end else begin
      warn_q <= warn_d;
    end
  end

  assign warn = warn_q;
`else
  // Threshold has no effect without the warning feature; output is a constant 0.
  assign warn = 1'b0 & (WARN_THRESH != 0);
`endif

endmodule

// File: tb/tb_round_timer.sv
// Scoreboard bench for round_timer: directed scenarios then random traffic against a unit-count model.
module tb_round_timer;

  localparam int unsigned TPU   = 2;
  localparam int unsigned WTHR  = 3;
  localparam int          MIdle = 0;
  localparam int          MRun  = 1;
  localparam int          MPaus = 2;
  localparam int          MDone = 3;

  logic       clk = 1'b0;
  logic       reset, tick, start, pause, clear;
  logic [7:0] load_val;
  logic [7:0] remaining;
  logic       running, expired, done, warn;

  typedef struct packed {
    logic [7:0] rem;
    logic       run;
    logic       exp;
    logic       done;
    logic       warn;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Reference model: remaining units, ticks accumulated towards the next unit, and mode.
  int   m_mode  = MIdle;
  int   m_units = 0;
  int   m_acc   = 0;
  bit   m_exp   = 1'b0;

`ifdef ROUND_TIMER_WARN_EN
  localparam bit WarnEn = 1'b1;
`else
  localparam bit WarnEn = 1'b0;
`endif

  round_timer #(
    .W             (8),
    .TICKS_PER_UNIT(TPU),
    .WARN_THRESH   (WTHR)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .start    (start),
    .load_val (load_val),
    .pause    (pause),
    .clear    (clear),
    .remaining(remaining),
    .running  (running),
    .expired  (expired),
    .done     (done),
    .warn     (warn)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit st, input int lv, input bit ps,
                            input bit cl, input bit tk);
    m_exp = 1'b0;
    if (rst || cl) begin
      m_mode  = MIdle;
      m_units = 0;
      m_acc   = 0;
    end else if (st) begin
      m_acc   = 0;
      m_units = lv;
      m_mode  = (lv == 0) ? MDone : MRun;
      m_exp   = (lv == 0);
    end else if (m_mode == MRun && ps) begin
      m_mode = MPaus;
    end else if (m_mode == MPaus && !ps) begin
      m_mode = MRun;
    end else if (m_mode == MRun && tk) begin
      m_acc++;
      if (m_acc == TPU) begin
        m_acc = 0;
        m_units--;
        if (m_units == 0) begin
          m_mode = MDone;
          m_exp  = 1'b1;
        end
      end
    end
  endtask

  task automatic drive(input bit rst, input bit st, input int lv, input bit ps, input bit cl);
    exp_t e;
    bit   tk;
    tk       = (cyc % 4 == 3);
    reset    = rst;
    start    = st;
    load_val = lv[7:0];
    pause    = ps;
    clear    = cl;
    tick     = tk;
    model_step(rst, st, lv, ps, cl, tk);
    e.rem  = m_units[7:0];
    e.run  = (m_mode == MRun) || (m_mode == MPaus);
    e.exp  = m_exp;
    e.done = (m_mode == MDone);
    e.warn = WarnEn && e.run && (m_units >= 1) && (m_units <= WTHR);
    sb_q.push_back(e);
    cyc++;
    @(negedge clk);
  endtask

  // Monitor: outputs are registered, so each edge presents one expected entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("remaining", int'(remaining), int'(e.rem));
        check("running", int'(running), int'(e.run));
        check("expired", int'(expired), int'(e.exp));
        check("done", int'(done), int'(e.done));
        check("warn", int'(warn), int'(e.warn));
      end
    end
  end

  initial begin
    int guard;
    bit ps;
    reset = 1'b1; start = 1'b0; pause = 1'b0; clear = 1'b0; tick = 1'b0; load_val = '0;

    repeat (3) drive(1, 0, 0, 0, 0);
    repeat (8) drive(0, 0, 0, 0, 0);

    drive(0, 1, 5, 0, 0);
    guard = 0;
    while (m_units != 3 && guard < 200) begin drive(0, 0, 0, 0, 0); guard++; end
    check("bound_rem3", int'(guard < 200), 1);
    repeat (24) drive(0, 0, 0, 1, 0);
    guard = 0;
    while (m_mode != MDone && guard < 200) begin drive(0, 0, 0, 0, 0); guard++; end
    check("bound_done", int'(guard < 200), 1);
    repeat (4) drive(0, 0, 0, 0, 0);

    drive(0, 1, 0, 0, 0);
    repeat (3) drive(0, 0, 0, 0, 0);

    drive(0, 1, 6, 0, 0);
    guard = 0;
    while (!(m_mode == MRun && m_units == 1 && m_acc == TPU - 1 && cyc % 4 == 3) &&
           guard < 300) begin
      drive(0, 0, 0, 0, 0);
      guard++;
    end
    check("bound_rem1_tick", int'(guard < 300), 1);
    drive(0, 1, 7, 0, 0);
    guard = 0;
    while (m_units != 4 && guard < 200) begin drive(0, 0, 0, 0, 0); guard++; end
    check("bound_rem4", int'(guard < 200), 1);
    drive(0, 0, 0, 0, 1);
    repeat (6) drive(0, 0, 0, 0, 0);

    ps = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 19) == 0) ps = ~ps;
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
            int'($urandom_range(0, 9)), ps, ($urandom_range(0, 79) == 0));
    end
    repeat (4) drive(0, 0, 0, 0, 0);

    @(posedge clk);
    #2;
    check("sb_drain", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
